// File: rtl/pfb_out_snap_ctrl.sv
// ---------------------------------------------------------------------------
// pfb_out_snap_ctrl
//
// Capture controller feeding port A of the PFB output snapshot BRAM.
// After software raises arm, the controller waits for the next frame start.
// With WAIT_SYNC=1 the frame starts on the first valid sample that carries
// sync. With WAIT_SYNC=0 it starts on the first valid sample. From there it
// writes 2**ADDR_WIDTH consecutive valid samples into the BRAM. It then
// raises done so the CPU can read the buffer over port B.
//
// Ports
//   clk           fabric clock, rising edge
//   rst           asynchronous, active-high reset
//   arm           software arm level; a rising edge arms a capture
//   din           PFB output sample
//   din_valid     din qualifier
//   din_sync      PFB frame sync, meaningful only with din_valid
//   bram_we       BRAM port-A write enable
//   bram_en_a     BRAM port-A enable (mirrors bram_we)
//   bram_addr     BRAM port-A word address
//   bram_wr_data  BRAM port-A write data
//   busy          high while armed or capturing
//   done          high once the buffer is complete and stable
//   wr_count      words written in the current or last capture
// ---------------------------------------------------------------------------
module pfb_out_snap_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter bit WAIT_SYNC  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  din_sync,
  output logic                  bram_we,
  output logic                  bram_en_a,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   wr_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  state_t                  state_q;
  logic                    arm_q;
  logic                    last_q;       // final word has been accepted
  logic                    busy_q;
  logic                    done_q;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     wr_count_q, wr_count_d;
  logic                    bram_we_q;
  logic [ADDR_WIDTH-1:0]   bram_addr_q, bram_addr_d;
  logic [DATA_WIDTH-1:0]   bram_wr_data_q, bram_wr_data_d;

  logic arm_rise;
  logic start;
  logic accept;
  logic accept_last;
  logic enter_armed;

  // A rising edge only counts once arm_q has seen arm low. arm_q resets to 1,
  // so an arm level held high through reset does not arm a capture.
  assign arm_rise = arm & ~arm_q;
  assign start    = WAIT_SYNC ? (din_valid & din_sync) : din_valid;

  // A sample is taken on the frame start in ARMED, or on any valid cycle in
  // CAPTURE until the final word has been accepted. Sync is ignored once the
  // capture is running.
  assign accept = ((state_q == S_ARMED) & start) |
                  ((state_q == S_CAPTURE) & din_valid & ~last_q);
  assign accept_last = accept & (addr_q == {ADDR_WIDTH{1'b1}});

  // Re-arming is only possible from IDLE or DONE. A rising edge of arm in
  // ARMED or CAPTURE never restarts a frame.
  assign enter_armed = arm_rise & ((state_q == S_IDLE) | (state_q == S_DONE));

  // NOTE: every signal written in this block is given a default first. A path
  // that leaves a signal unassigned would infer a latch.
  always_comb begin
    addr_d         = addr_q;
    wr_count_d     = wr_count_q;
    bram_addr_d    = bram_addr_q;
    bram_wr_data_d = bram_wr_data_q;

    // wr_count tracks the strobes themselves, so it reaches its full value on
    // the same cycle that done rises.
    if (bram_we_q) begin
      wr_count_d = wr_count_q + CNT_ONE;
    end

    if (accept) begin
      bram_addr_d    = addr_q;
      bram_wr_data_d = din;
      addr_d         = addr_q + ADDR_ONE;
    end

    // enter_armed cannot coincide with accept or with a strobe: it only fires
    // in IDLE or DONE, and neither state has a write in flight.
    if (enter_armed) begin
      addr_d     = '0;
      wr_count_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then updates from the values before the edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_q          <= 1'b1;
      addr_q         <= '0;
      wr_count_q     <= '0;
      bram_we_q      <= 1'b0;
      bram_addr_q    <= '0;
      bram_wr_data_q <= '0;
    end else begin
      arm_q          <= arm;
      addr_q         <= addr_d;
      wr_count_q     <= wr_count_d;
      bram_we_q      <= accept;
      bram_addr_q    <= bram_addr_d;
      bram_wr_data_q <= bram_wr_data_d;
    end
  end

  // Control FSM. busy and done are registered together with the state, so
  // both outputs change on the same edge as the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A start that coincides with the arm edge is not captured.
          if (arm_rise) begin
            state_q <= S_ARMED;
            busy_q  <= 1'b1;
          end
        end
        S_ARMED: begin
          if (start) begin
            state_q <= S_CAPTURE;
            last_q  <= accept_last;
          end
        end
        S_CAPTURE: begin
          if (accept_last) begin
            last_q <= 1'b1;
          end
          // Move to DONE on the edge that ends the final strobe. The last word
          // is therefore committed before done is seen.
          if (last_q && bram_we_q) begin
            state_q <= S_DONE;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          if (arm_rise) begin
            state_q <= S_ARMED;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bram_we      = bram_we_q;
  assign bram_en_a    = bram_we_q;
  assign bram_addr    = bram_addr_q;
  assign bram_wr_data = bram_wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign wr_count     = wr_count_q;

endmodule
